irda_fir_rx_ctrl: RTL and testbench
===================================

# irda_fir_rx_ctrl

FIR (4 Mb/s, 4PPM) receive sequencer wrapped around the FIR bit synchronizer. It drives `bs_restart` on that synchronizer and consumes its `bs_o` chip stream. It hunts for lock, qualifies the 16-chip preamble and consumes the start flag. It then decodes 4PPM chip quads into 2-bit symbols for the FIR deframer, and ends the frame (and resynchronizes) on any illegal quad or lock timeout.

## Interface
- `CHIP_TICKS`, default 5: `fast_enable` ticks per chip.
- `PRE_MIN`, default 4: consecutive aligned preamble repetitions required before start flag is accepted.
- `HUNT_TMO`, default 4095: `fast_enable` ticks allowed in HUNT/ALIGN without progress before restart.
- `clk` in 1: system clock.
- `wb_rst_i` in 1: reset. Synchronous, active-high.
- `rx_enable` in 1: FIR receive enable from control register.
- `fast_enable` in 1: 40 MHz tick qualifier.
- `bs_i` in 1: chip from bit synchronizer `bs_o`.
- `bs_restart` out 1: restart to bit synchronizer.
- `sym_o` out 2: decoded 4PPM symbol.
- `sym_valid` out 1: one-clk strobe; `sym_o` valid.
- `frame_start` out 1: one-clk pulse, start flag accepted.
- `frame_end` out 1: one-clk pulse, frame terminated (illegal quad).
- `sync_err` out 1: one-clk pulse, hunt timeout or preamble loss.

## Operation
- States: IDLE, HUNT, ALIGN, PREAMBLE, DATA.
- IDLE: `bs_restart`=1. Leaves to HUNT on the first clk with `rx_enable`=1.
- HUNT: `bs_restart`=0. Waits for `bs_i` 0→1 (synchronizer lock), sampled on `fast_enable` ticks. On lock, the tick counter is cleared.
- Chip strobe: the first chip is sampled CHIP_TICKS+1 ticks after the lock tick. Subsequent chips are sampled every CHIP_TICKS ticks. Each sampled chip shifts into a 16-bit window, MSB = oldest.
- ALIGN: each chip compares the window to preamble 1000_0000_1010_1000. On a match: go to PREAMBLE with rep count 1 and the 16-chip group counter cleared.
- PREAMBLE: on every 16th chip, compare the window.
  - Match: rep count increments, saturating at PRE_MIN.
  - Mismatch with rep count ≥ PRE_MIN: the group is the start flag. Pulse `frame_start` and go to DATA.
  - Mismatch with rep count < PRE_MIN: pulse `sync_err` and restart.
- DATA: on every 4th chip, decode the last quad.
  - 1000→00, 0100→01, 0010→10, 0001→11: `sym_valid`=1 for one clk.
  - Any other quad: pulse `frame_end`, no `sym_valid`, restart.
- Restart sequence: one clk with `bs_restart`=1, window and counters cleared, then HUNT. The window must be cleared so stale chips cannot match.
- Timeout: the tick counter runs in HUNT and ALIGN. Reaching HUNT_TMO pulses `sync_err` and restarts. It does not run in PREAMBLE or DATA.
- `rx_enable` low in any state: go to IDLE next clk. No pulses are emitted. A frame aborted in DATA gives no `frame_end`.

## Timing
- Reset (`wb_rst_i`=1 at a clk edge): state IDLE, `bs_restart`=1, all other outputs 0, counters and window 0.
- All outputs are registered. Pulses are exactly one clk wide, independent of `fast_enable` spacing.
- `sym_valid` rises on the clk following the `fast_enable` tick that sampled the 4th chip of the quad. Latency from that sample is 1 clk.
- `frame_start` is asserted on the clk after the sample of the last chip of the start-flag group. The first `sym_valid` follows 4 chips later.
- Simultaneous events, in priority order: `wb_rst_i` > `rx_enable`=0 > timeout > chip decision. A `frame_end` and a timeout on the same clk cannot both pulse (timeout is inactive in DATA).
- `bs_restart` is asserted for exactly 1 clk per restart, and continuously in IDLE.

## Test plan
- Reset mid-DATA: assert `wb_rst_i` for 1 clk → next clk IDLE, `bs_restart`=1, all pulses 0. Then `rx_enable`=1 → `bs_restart`=0 one clk later.
- Good frame: lock, 4 preambles, start flag 0000_1100_0000_1100, quads 1000, 0001, 0100 → `frame_start` once. `sym_o` 00, 11, 01 with three `sym_valid` strobes spaced 4 chips (20 ticks).
- Short preamble: lock, 2 preambles, then start flag → `sync_err` pulse, 1-clk `bs_restart`, no `frame_start`.
- Illegal quad: good frame, then quad 1100 → `frame_end` pulse, no `sym_valid` for that quad, `bs_restart` 1 clk, state HUNT.
- Hunt timeout: `bs_i` held 0 with `fast_enable` every clk → `sync_err` after 4095 ticks, then restart and repeat.
- `rx_enable` dropped in DATA → IDLE next clk, `bs_restart`=1, no `frame_end` or `sync_err`.

Source files
------------

// File: rtl/irda_fir_rx_ctrl_if.sv
// Signal bundle between the FIR receive sequencer and its environment
// (bit synchronizer chip stream, control enables, deframer symbol outputs).
interface irda_fir_rx_ctrl_if;
    logic       rx_enable;
    logic       fast_enable;
    logic       bs_i;
    logic       bs_restart;
    logic [1:0] sym_o;
    logic       sym_valid;
    logic       frame_start;
    logic       frame_end;
    logic       sync_err;

    modport master (
        output rx_enable, fast_enable, bs_i,
        input  bs_restart, sym_o, sym_valid, frame_start, frame_end, sync_err
    );

    modport slave (
        input  rx_enable, fast_enable, bs_i,
        output bs_restart, sym_o, sym_valid, frame_start, frame_end, sync_err
    );
endinterface

// File: rtl/irda_fir_rx_ctrl.sv
// FIR 4PPM receive sequencer: hunts for synchronizer lock, qualifies the
// preamble, accepts the start flag and decodes chip quads into symbols.
module irda_fir_rx_ctrl #(
    parameter int CHIP_TICKS = 5,
    parameter int PRE_MIN    = 4,
    parameter int HUNT_TMO   = 4095
) (
    input  logic              clk,
    input  logic              wb_rst_i,
    irda_fir_rx_ctrl_if.slave bus_if
);
    localparam logic [15:0] PREAMBLE_PAT = 16'b1000_0000_1010_1000;
    localparam int PW = $clog2(CHIP_TICKS + 2);
    localparam int TW = $clog2(HUNT_TMO + 1);
    localparam int RW = $clog2(PRE_MIN + 1);

    typedef enum logic [2:0] {IDLE, HUNT, ALIGN, PREAMBLE, DATA} state_t;

    state_t        state_q;
    logic          bs_restart_q;
    logic [1:0]    sym_q;
    logic          sym_valid_q;
    logic          frame_start_q;
    logic          frame_end_q;
    logic          sync_err_q;
    logic [15:0]   window_q;
    logic [3:0]    chip_cnt_q;
    logic [PW-1:0] phase_q;
    logic          first_q;
    logic          prev_bs_q;
    logic [TW-1:0] tmo_q;
    logic [RW-1:0] rep_q;

    logic          tick;
    logic          in_chip_state;
    logic [PW-1:0] phase_lim;
    logic          chip_stb;
    logic          tmo_hit;
    logic          lock;
    logic [15:0]   window_d;
    logic          pre_match;
    logic          group_end;
    logic          quad_end;
    logic          quad_ok;
    logic [1:0]    sym_dec;
    logic          pre_fail;
    logic          quad_bad;
    logic          restart_ev;

    // Ticks are ignored during the single restart clk so the synchronizer
    // sees a clean restart before lock detection resumes.
    assign tick          = bus_if.fast_enable && !bs_restart_q;
    assign in_chip_state = (state_q == ALIGN) || (state_q == PREAMBLE) || (state_q == DATA);
    assign phase_lim     = first_q ? PW'(CHIP_TICKS + 1) : PW'(CHIP_TICKS);
    assign chip_stb      = tick && in_chip_state && ((phase_q + PW'(1)) == phase_lim);
    assign tmo_hit       = tick && ((state_q == HUNT) || (state_q == ALIGN))
                           && (tmo_q == TW'(HUNT_TMO - 1));
    assign lock          = tick && (state_q == HUNT) && !prev_bs_q && bus_if.bs_i;
    assign window_d      = {window_q[14:0], bus_if.bs_i};
    assign pre_match     = (window_d == PREAMBLE_PAT);
    assign group_end     = (chip_cnt_q == 4'd15);
    assign quad_end      = (chip_cnt_q[1:0] == 2'd3);

    always_comb begin
        sym_dec = 2'd0;
        quad_ok = 1'b1;
        case (window_d[3:0])
            4'b1000: sym_dec = 2'd0;
            4'b0100: sym_dec = 2'd1;
            4'b0010: sym_dec = 2'd2;
            4'b0001: sym_dec = 2'd3;
            default: quad_ok = 1'b0;
        endcase
    end

    assign pre_fail   = chip_stb && (state_q == PREAMBLE) && group_end && !pre_match
                        && (rep_q < RW'(PRE_MIN));
    assign quad_bad   = chip_stb && (state_q == DATA) && quad_end && !quad_ok;
    assign restart_ev = tmo_hit || pre_fail || quad_bad;

    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            state_q       <= IDLE;
            bs_restart_q  <= 1'b1;
            sym_q         <= 2'd0;
            sym_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            sync_err_q    <= 1'b0;
            window_q      <= '0;
            chip_cnt_q    <= '0;
            phase_q       <= '0;
            first_q       <= 1'b0;
            prev_bs_q     <= 1'b0;
            tmo_q         <= '0;
            rep_q         <= '0;
        end else begin
            sym_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            sync_err_q    <= 1'b0;
            if (!bus_if.rx_enable || (state_q == IDLE) || restart_ev) begin
                // Every exit path wipes the window so stale chips cannot match.
                window_q   <= '0;
                chip_cnt_q <= '0;
                phase_q    <= '0;
                first_q    <= 1'b0;
                prev_bs_q  <= 1'b0;
                tmo_q      <= '0;
                rep_q      <= '0;
                if (!bus_if.rx_enable) begin
                    state_q      <= IDLE;
                    bs_restart_q <= 1'b1;
                end else if (state_q == IDLE) begin
                    state_q      <= HUNT;
                    bs_restart_q <= 1'b0;
                end else begin
                    state_q      <= HUNT;
                    bs_restart_q <= 1'b1;
                    sync_err_q   <= tmo_hit || pre_fail;
                    frame_end_q  <= quad_bad;
                end
            end else begin
                bs_restart_q <= 1'b0;
                if (tick && (state_q == HUNT)) begin
                    prev_bs_q <= bus_if.bs_i;
                    if (lock) begin
                        state_q <= ALIGN;
                        tmo_q   <= '0;
                        phase_q <= '0;
                        first_q <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end else if (tick && in_chip_state) begin
                    if (state_q == ALIGN) begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                    phase_q <= chip_stb ? '0 : phase_q + PW'(1);
                    if (chip_stb) begin
                        first_q    <= 1'b0;
                        window_q   <= window_d;
                        chip_cnt_q <= chip_cnt_q + 4'd1;
                        case (state_q)
                            ALIGN: begin
                                if (pre_match) begin
                                    state_q    <= PREAMBLE;
                                    rep_q      <= RW'(1);
                                    chip_cnt_q <= '0;
                                end
                            end
                            PREAMBLE: begin
                                if (group_end) begin
                                    if (pre_match) begin
                                        if (rep_q != RW'(PRE_MIN)) begin
                                            rep_q <= rep_q + RW'(1);
                                        end
                                    end else begin
                                        frame_start_q <= 1'b1;
                                        state_q       <= DATA;
                                        chip_cnt_q    <= '0;
                                    end
                                end
                            end
                            DATA: begin
                                if (quad_end) begin
                                    sym_valid_q <= 1'b1;
                                    sym_q       <= sym_dec;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    assign bus_if.bs_restart  = bs_restart_q;
    assign bus_if.sym_o       = sym_q;
    assign bus_if.sym_valid   = sym_valid_q;
    assign bus_if.frame_start = frame_start_q;
    assign bus_if.frame_end   = frame_end_q;
    assign bus_if.sync_err    = sync_err_q;
endmodule

// File: tb/tb_irda_fir_rx_ctrl.sv
// Bench for irda_fir_rx_ctrl: chip streams are built as arrays, expected events
// come from a group/quad-indexed reference model, observed events are logged per clk.
module tb_irda_fir_rx_ctrl;
    localparam int CT       = 5;
    localparam int PRE_MIN  = 4;
    localparam int HUNT_TMO = 4095;
    localparam logic [15:0] PRE  = 16'b1000_0000_1010_1000;
    localparam logic [15:0] FLAG = 16'b0000_1100_0000_1100;
    localparam int K_SYM = 0, K_FS = 1, K_FE = 2, K_SE = 3, K_RST = 4;

    typedef struct {
        int kind;
        int sym;
        int t;
        bit fe;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    irda_fir_rx_ctrl_if bus ();

    irda_fir_rx_ctrl #(
        .CHIP_TICKS(CT),
        .PRE_MIN   (PRE_MIN),
        .HUNT_TMO  (HUNT_TMO)
    ) dut (
        .clk     (clk),
        .wb_rst_i(rst),
        .bus_if  (bus)
    );

    int   tests = 0;
    int   fails = 0;
    bit   chips[$];
    ev_t  exp_q[$];
    ev_t  obs_q[$];
    bit   last_rx  = 1'b0;
    bit   last_rst = 1'b1;
    bit   last_fe  = 1'b0;
    int   last_t   = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clk: log what the DUT produced on the last edge, then drive the next inputs.
    task automatic step(input bit rx, input bit rs, input bit fe, input bit bsv, input int t);
        @(negedge clk);
        if (bus.sym_valid !== 1'b0)   obs_q.push_back('{K_SYM, int'(bus.sym_o), last_t, last_fe});
        if (bus.frame_start !== 1'b0) obs_q.push_back('{K_FS, 0, last_t, last_fe});
        if (bus.frame_end !== 1'b0)   obs_q.push_back('{K_FE, 0, last_t, last_fe});
        if (bus.sync_err !== 1'b0)    obs_q.push_back('{K_SE, 0, last_t, last_fe});
        if (last_rx && !last_rst && bus.bs_restart !== 1'b0)
            obs_q.push_back('{K_RST, 0, last_t, last_fe});
        rst             = rs;
        bus.rx_enable   = rx;
        bus.fast_enable = fe;
        bus.bs_i        = bsv;
        last_rx  = rx;
        last_rst = rs;
        last_fe  = fe;
        last_t   = t;
    endtask

    function automatic int tick_of(int k);
        return CT + 1 + CT * k;
    endfunction

    function automatic bit chip_at(int t);
        int k;
        if (t < 2) return 1'b1;
        k = (t - 2) / CT;
        return (k < chips.size()) ? chips[k] : 1'b0;
    endfunction

    function automatic logic [15:0] grp(int k);
        logic [15:0] g = '0;
        for (int i = 0; i < 16; i++) begin
            int idx = k - 15 + i;
            if (idx >= 0 && idx < chips.size()) g[15 - i] = chips[idx];
        end
        return g;
    endfunction

    // Reference: find the first aligned preamble, walk 16-chip groups, then 4-chip quads.
    // Returns the chip index of the terminating event, or -1 if the stream runs out.
    function automatic int build_expected();
        int k = 0;
        int rep;
        int n = chips.size();
        logic [15:0] g;
        exp_q.delete();
        while (k < n && grp(k) !== PRE) k++;
        if (k >= n) return -1;
        rep = 1;
        while (1'b1) begin
            k += 16;
            if (k >= n) return -1;
            if (grp(k) === PRE) begin
                if (rep < PRE_MIN) rep++;
            end else if (rep >= PRE_MIN) begin
                exp_q.push_back('{K_FS, 0, tick_of(k), 1'b1});
                break;
            end else begin
                exp_q.push_back('{K_SE, 0, tick_of(k), 1'b1});
                exp_q.push_back('{K_RST, 0, tick_of(k), 1'b1});
                return k;
            end
        end
        while (1'b1) begin
            k += 4;
            if (k >= n) return -1;
            g = grp(k);
            case (g[3:0])
                4'b1000: exp_q.push_back('{K_SYM, 0, tick_of(k), 1'b1});
                4'b0100: exp_q.push_back('{K_SYM, 1, tick_of(k), 1'b1});
                4'b0010: exp_q.push_back('{K_SYM, 2, tick_of(k), 1'b1});
                4'b0001: exp_q.push_back('{K_SYM, 3, tick_of(k), 1'b1});
                default: begin
                    exp_q.push_back('{K_FE, 0, tick_of(k), 1'b1});
                    exp_q.push_back('{K_RST, 0, tick_of(k), 1'b1});
                    return k;
                end
            endcase
        end
        return -1;
    endfunction

    task automatic push_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) chips.push_back(w[i]);
    endtask

    task automatic push_quad(input logic [3:0] q);
        for (int i = 3; i >= 0; i--) chips.push_back(q[i]);
    endtask

    task automatic drive_frame(input bit gaps, input bit trail);
        int term_k;
        int last_tick;
        term_k = build_expected();
        step(1'b0, 1'b0, 1'b0, 1'b0, -1);
        obs_q.delete();
        step(1'b0, 1'b0, 1'b0, 1'b0, -1);
        step(1'b1, 1'b0, 1'b0, 1'b0, -1);
        step(1'b1, 1'b0, 1'b1, 1'b0, -1);
        step(1'b1, 1'b0, 1'b1, 1'b0, -1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 0);
        last_tick = (term_k >= 0) ? tick_of(term_k) : tick_of(chips.size() - 1);
        for (int t = 1; t <= last_tick; t++) begin
            if (gaps) repeat ($urandom_range(0, 2)) step(1'b1, 1'b0, 1'b0, chip_at(t), t);
            step(1'b1, 1'b0, 1'b1, chip_at(t), t);
        end
        if (trail) begin
            for (int t = last_tick + 1; t <= last_tick + 12; t++) step(1'b1, 1'b0, 1'b1, 1'b0, t);
        end
    endtask

    task automatic compare_events(input string tag);
        check({tag, " event count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check($sformatf("%s ev%0d kind", tag, i), obs_q[i].kind, exp_q[i].kind);
            check($sformatf("%s ev%0d sym", tag, i), obs_q[i].sym, exp_q[i].sym);
            check($sformatf("%s ev%0d tick", tag, i), obs_q[i].t, exp_q[i].t);
            check($sformatf("%s ev%0d latency", tag, i), obs_q[i].fe, exp_q[i].fe);
        end
        $display("[TB] %s: %0d events expected, %0d observed", tag, exp_q.size(), obs_q.size());
    endtask

    initial begin
        int n_sym;
        int n_rep;
        logic [3:0] q;
        bus.rx_enable   = 1'b0;
        bus.fast_enable = 1'b0;
        bus.bs_i        = 1'b0;

        // Reset state
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, -1);
        check("reset bs_restart", bus.bs_restart, 1'b1);
        check("reset sym_valid", bus.sym_valid, 1'b0);
        check("reset sym_o", bus.sym_o, 2'd0);
        check("reset frame_start", bus.frame_start, 1'b0);
        check("reset frame_end", bus.frame_end, 1'b0);
        check("reset sync_err", bus.sync_err, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, -1);

        // Good frame terminated by an illegal quad
        chips.delete();
        repeat (4) push_word(PRE);
        push_word(FLAG);
        push_quad(4'b1000);
        push_quad(4'b0001);
        push_quad(4'b0100);
        push_quad(4'b1100);
        drive_frame(1'b0, 1'b1);
        compare_events("good frame");

        // Short preamble
        chips.delete();
        repeat (2) push_word(PRE);
        push_word(FLAG);
        push_quad(4'b1000);
        drive_frame(1'b0, 1'b1);
        compare_events("short preamble");

        // Randomized frames with irregular fast_enable spacing
        for (int r = 0; r < 6; r++) begin
            chips.delete();
            n_rep = $urandom_range(1, 6);
            n_sym = $urandom_range(1, 6);
            repeat (n_rep) push_word(PRE);
            push_word(FLAG);
            repeat (n_sym) begin
                q = 4'b1000 >> $urandom_range(0, 3);
                push_quad(q);
            end
            do q = 4'($urandom_range(0, 15)); while ($countones(q) == 1);
            push_quad(q);
            drive_frame(1'b1, 1'b1);
            compare_events($sformatf("random frame %0d reps=%0d syms=%0d", r, n_rep, n_sym));
        end

        // rx_enable dropped mid-quad in DATA
        chips.delete();
        repeat (5) push_word(PRE);
        push_word(FLAG);
        push_quad(4'b0010);
        push_quad(4'b0001);
        chips.push_back(1'b1);
        chips.push_back(1'b0);
        drive_frame(1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, -1);
        step(1'b0, 1'b0, 1'b0, 1'b0, -1);
        check("rx drop bs_restart", bus.bs_restart, 1'b1);
        repeat (4) step(1'b0, 1'b0, 1'b1, 1'b0, -1);
        compare_events("rx drop in DATA");

        // Reset mid-DATA with rx_enable held high
        chips.delete();
        repeat (4) push_word(PRE);
        push_word(FLAG);
        push_quad(4'b1000);
        chips.push_back(1'b0);
        chips.push_back(1'b1);
        drive_frame(1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, -1);
        step(1'b1, 1'b0, 1'b0, 1'b0, -1);
        check("mid reset bs_restart", bus.bs_restart, 1'b1);
        check("mid reset sym_valid", bus.sym_valid, 1'b0);
        check("mid reset frame_start", bus.frame_start, 1'b0);
        check("mid reset frame_end", bus.frame_end, 1'b0);
        check("mid reset sync_err", bus.sync_err, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, -1);
        check("post reset bs_restart", bus.bs_restart, 1'b0);
        compare_events("reset mid DATA");

        // Hunt timeout, twice in a row; the restart clk's tick is not counted
        chips.delete();
        exp_q.delete();
        exp_q.push_back('{K_SE, 0, HUNT_TMO, 1'b1});
        exp_q.push_back('{K_RST, 0, HUNT_TMO, 1'b1});
        exp_q.push_back('{K_SE, 0, 2 * HUNT_TMO + 1, 1'b1});
        exp_q.push_back('{K_RST, 0, 2 * HUNT_TMO + 1, 1'b1});
        step(1'b0, 1'b0, 1'b0, 1'b0, -1);
        obs_q.delete();
        step(1'b0, 1'b0, 1'b0, 1'b0, -1);
        step(1'b1, 1'b0, 1'b0, 1'b0, -1);
        for (int t = 1; t <= 2 * HUNT_TMO + 8; t++) step(1'b1, 1'b0, 1'b1, 1'b0, t);
        compare_events("hunt timeout");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
